// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus, hazard/redirect controls and IF/ID
// pipeline register outputs of the fetch stage, bundled for port connection.
// The master modport is the fetch stage itself; slave is its environment.
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        align_err;

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  flush,
        input  br_taken,
        input  br_target,
        output if_id_pc,
        output if_id_pc4,
        output if_id_instr,
        output if_id_valid,
        output halted,
        output align_err
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output flush,
        output br_taken,
        output br_target,
        input  if_id_pc,
        input  if_id_pc4,
        input  if_id_instr,
        input  if_id_valid,
        input  halted,
        input  align_err
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC register plus IF/ID pipeline register with BOOT/RUN/HALT
// control. Redirects beat flush, flush beats stall, stall beats advance.
// A fetched HALT_WORD parks the stage until a redirect arrives.
// Optional macro FETCH_PERF_EN adds perf_fetch/perf_bubble counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_stage_if.master      bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_bubble
`endif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] aligned_target;
    logic        target_misaligned;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        halted_q;
    logic        align_err_q;

    assign pc_plus4          = pc + 32'd4;
    assign aligned_target    = {bus.br_target[31:2], 2'b00};
    assign target_misaligned = (bus.br_target[1:0] != 2'b00);

    assign bus.imem_addr   = pc;
    assign bus.if_id_pc    = id_pc;
    assign bus.if_id_pc4   = id_pc4;
    assign bus.if_id_instr = id_instr;
    assign bus.if_id_valid = id_valid;
    assign bus.halted      = halted_q;
    assign bus.align_err   = align_err_q;

    // Control FSM, PC and IF/ID register update with redirect > flush > stall priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            id_pc       <= 32'h0;
            id_pc4      <= 32'h0;
            id_instr    <= 32'h0;
            id_valid    <= 1'b0;
            halted_q    <= 1'b0;
            align_err_q <= 1'b0;
`ifdef FETCH_PERF_EN
            perf_fetch  <= 32'h0;
            perf_bubble <= 32'h0;
`endif
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (bus.br_taken) begin
                        pc       <= aligned_target;
                        id_pc    <= 32'h0;
                        id_pc4   <= 32'h0;
                        id_instr <= 32'h0;
                        id_valid <= 1'b0;
                        if (target_misaligned) begin
                            align_err_q <= 1'b1;
                        end
`ifdef FETCH_PERF_EN
                        perf_bubble <= perf_bubble + 32'd1;
`endif
                    end else if (bus.flush) begin
                        id_pc    <= 32'h0;
                        id_pc4   <= 32'h0;
                        id_instr <= 32'h0;
                        id_valid <= 1'b0;
                        if (!bus.stall) begin
                            pc <= pc_plus4;
                        end
`ifdef FETCH_PERF_EN
                        perf_bubble <= perf_bubble + 32'd1;
`endif
                    end else if (bus.stall) begin
                        state <= RUN;
                    end else if (bus.imem_instr == HALT_WORD) begin
                        id_pc    <= 32'h0;
                        id_pc4   <= 32'h0;
                        id_instr <= 32'h0;
                        id_valid <= 1'b0;
                        halted_q <= 1'b1;
                        state    <= HALT;
`ifdef FETCH_PERF_EN
                        perf_bubble <= perf_bubble + 32'd1;
`endif
                    end else begin
                        id_pc    <= pc;
                        id_pc4   <= pc_plus4;
                        id_instr <= bus.imem_instr;
                        id_valid <= 1'b1;
                        pc       <= pc_plus4;
`ifdef FETCH_PERF_EN
                        perf_fetch <= perf_fetch + 32'd1;
`endif
                    end
                end
                HALT: begin
                    if (bus.br_taken) begin
                        pc       <= aligned_target;
                        id_pc    <= 32'h0;
                        id_pc4   <= 32'h0;
                        id_instr <= 32'h0;
                        id_valid <= 1'b0;
                        halted_q <= 1'b0;
                        state    <= RUN;
                        if (target_misaligned) begin
                            align_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. Each scenario queues
// per-cycle stimulus together with the IF/ID and PC values expected after
// that edge, then replays the queue and compares against the DUT.
module tb_fetch_stage;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic        aerr;
    } obs_t;

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        br;
        logic [31:0] target;
    } stim_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    obs_t  exp_q[$];
    stim_t stim_q[$];

    fetch_stage_if bus();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;
`endif

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .HALT_WORD (HALT_WORD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_bubble (perf_bubble)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Instruction memory model: a few fixed words, otherwise an address-derived pattern.
    always_comb begin
        case (bus.imem_addr)
            32'h0000_0000: bus.imem_instr = 32'h1111_1111;
            32'h0000_0004: bus.imem_instr = 32'h2222_2222;
            32'h0000_0008: bus.imem_instr = 32'h3333_3333;
            32'h0000_000C: bus.imem_instr = HALT_WORD;
            default:       bus.imem_instr = 32'h5A00_0000 ^ bus.imem_addr;
        endcase
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic obs_t sample();
        obs_t o;
        o.addr   = bus.imem_addr;
        o.pc     = bus.if_id_pc;
        o.pc4    = bus.if_id_pc4;
        o.instr  = bus.if_id_instr;
        o.valid  = bus.if_id_valid;
        o.halted = bus.halted;
        o.aerr   = bus.align_err;
        return o;
    endfunction

    task automatic push_exp(input logic [31:0] a, input logic [31:0] p, input logic [31:0] p4,
                            input logic [31:0] i, input logic v, input logic h, input logic e);
        obs_t t;
        t.addr   = a;
        t.pc     = p;
        t.pc4    = p4;
        t.instr  = i;
        t.valid  = v;
        t.halted = h;
        t.aerr   = e;
        exp_q.push_back(t);
    endtask

    task automatic queue_cycle(input logic s, input logic f, input logic b, input logic [31:0] tgt,
                               input logic [31:0] a, input logic [31:0] p, input logic [31:0] p4,
                               input logic [31:0] i, input logic v, input logic h, input logic e);
        stim_t st;
        st.stall  = s;
        st.flush  = f;
        st.br     = b;
        st.target = tgt;
        stim_q.push_back(st);
        push_exp(a, p, p4, i, v, h, e);
    endtask

    task automatic step(input stim_t st);
        @(negedge clk);
        bus.stall     = st.stall;
        bus.flush     = st.flush;
        bus.br_taken  = st.br;
        bus.br_target = st.target;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0;
        push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        o = sample(); e = exp_q.pop_front(); n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got %h want %h", o, e);
        end
`ifdef FETCH_PERF_EN
        n_cmp++;
        if ({perf_fetch, perf_bubble} !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_perf: got %h/%h want 0/0", perf_fetch, perf_bubble);
        end
`endif
        // One BOOT cycle: PC still at reset value, IF/ID still a bubble.
        push_exp(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        o = sample(); e = exp_q.pop_front(); n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL boot_bubble: got %h want %h", o, e);
        end
    endtask

    task automatic test_sequential();
        obs_t o, e;
        queue_cycle(0, 0, 0, 0, 32'h4, 32'h0, 32'h4, 32'h1111_1111, 1, 0, 0);
        queue_cycle(0, 0, 0, 0, 32'h8, 32'h4, 32'h8, 32'h2222_2222, 1, 0, 0);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL sequential[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_stall();
        obs_t o, e;
        queue_cycle(1, 0, 0, 0, 32'h8, 32'h4, 32'h8, 32'h2222_2222, 1, 0, 0);
        queue_cycle(1, 0, 0, 0, 32'h8, 32'h4, 32'h8, 32'h2222_2222, 1, 0, 0);
        queue_cycle(0, 0, 0, 0, 32'hC, 32'h8, 32'hC, 32'h3333_3333, 1, 0, 0);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL stall[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_halt();
        obs_t o, e;
        // Stalled while the halt word is presented: still RUN.
        queue_cycle(1, 0, 0, 0, 32'hC, 32'h8, 32'hC, 32'h3333_3333, 1, 0, 0);
        // Advancing edge enters HALT with PC frozen at 0x0C.
        queue_cycle(0, 0, 0, 0, 32'hC, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        for (int n = 0; n < 10; n++) begin
            queue_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0,
                        32'hC, 32'h0, 32'h0, 32'h0, 0, 1, 0);
        end
        queue_cycle(0, 0, 1, 32'h20, 32'h20, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        queue_cycle(0, 0, 0, 0, 32'h24, 32'h20, 32'h24, 32'h5A00_0020, 1, 0, 0);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL halt[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_flush();
        obs_t o, e;
        queue_cycle(0, 0, 0, 0, 32'h28, 32'h24, 32'h28, 32'h5A00_0024, 1, 0, 0);
        queue_cycle(0, 1, 0, 0, 32'h2C, 32'h0,  32'h0,  32'h0,         0, 0, 0);
        queue_cycle(0, 0, 0, 0, 32'h30, 32'h2C, 32'h30, 32'h5A00_002C, 1, 0, 0);
        queue_cycle(1, 1, 0, 0, 32'h30, 32'h0,  32'h0,  32'h0,         0, 0, 0);
        queue_cycle(0, 0, 0, 0, 32'h34, 32'h30, 32'h34, 32'h5A00_0030, 1, 0, 0);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL flush[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_redirect();
        obs_t o, e;
        queue_cycle(1, 0, 1, 32'h40, 32'h40, 32'h0,  32'h0,  32'h0,         0, 0, 0);
        queue_cycle(0, 0, 0, 0,      32'h44, 32'h40, 32'h44, 32'h5A00_0040, 1, 0, 0);
        queue_cycle(0, 1, 1, 32'h80, 32'h80, 32'h0,  32'h0,  32'h0,         0, 0, 0);
        queue_cycle(0, 0, 0, 0,      32'h84, 32'h80, 32'h84, 32'h5A00_0080, 1, 0, 0);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL redirect[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_misaligned();
        obs_t o, e;
        queue_cycle(0, 0, 1, 32'h43, 32'h40, 32'h0,  32'h0,  32'h0,         0, 0, 1);
        queue_cycle(0, 0, 0, 0,      32'h44, 32'h40, 32'h44, 32'h5A00_0040, 1, 0, 1);
        queue_cycle(0, 0, 0, 0,      32'h48, 32'h44, 32'h48, 32'h5A00_0044, 1, 0, 1);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL misaligned[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_wrap();
        obs_t o, e;
        queue_cycle(0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0, 0, 0, 1);
        queue_cycle(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'hA5FF_FFFC, 1, 0, 1);
        queue_cycle(0, 0, 0, 0, 32'h4, 32'h0, 32'h4, 32'h1111_1111, 1, 0, 1);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL wrap[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    task automatic test_reset_in_halt();
        obs_t o, e;
        queue_cycle(0, 0, 1, 32'hC, 32'hC, 32'h0, 32'h0, 32'h0, 0, 0, 1);
        queue_cycle(0, 0, 0, 0,     32'hC, 32'h0, 32'h0, 32'h0, 0, 1, 1);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL enter_halt[%0d]: got %h want %h", k, o, e);
            end
        end
        // Assert reset between edges: outputs must clear without a clock.
        push_exp(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        o = sample(); e = exp_q.pop_front(); n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h want %h", o, e);
        end
        // Release: exactly one BOOT bubble, then fetch from the reset PC.
        push_exp(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.stall = 1'b0; bus.flush = 1'b0; bus.br_taken = 1'b0; bus.br_target = 32'h0;
        @(posedge clk);
        #1;
        o = sample(); e = exp_q.pop_front(); n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("[TB] FAIL reboot_bubble: got %h want %h", o, e);
        end
        queue_cycle(0, 0, 0, 0, 32'h4, 32'h0, 32'h4, 32'h1111_1111, 1, 0, 0);
        for (int k = 0; stim_q.size() > 0; k++) begin
            step(stim_q.pop_front());
            o = sample(); e = exp_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("[TB] FAIL reboot_fetch[%0d]: got %h want %h", k, o, e);
            end
        end
    endtask

    // Scenario sequence.
    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_halt();
        test_flush();
        test_redirect();
        test_misaligned();
        test_wrap();
        test_reset_in_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
